// File: rtl/led_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_sched_pkg
// Brief    : Shared types, state codes and source encodings for the LED
//            strip frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package led_sched_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_SEND      = 3'd4,
        S_LATCH     = 3'd5
    } state_t;

    localparam logic [1:0] SRC_GAME = 2'd0;
    localparam logic [1:0] SRC_FX   = 2'd1;
    localparam logic [1:0] SRC_DBG  = 2'd2;

    // Modulo-N_REQ addition of two source indices.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'(N_REQ)) begin
            s = s - 3'(N_REQ);
        end
        return s[1:0];
    endfunction

endpackage : led_sched_pkg
`default_nettype wire

// File: rtl/led_sched_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_sched_arbiter
// Brief    : Combinational frame-source arbiter. Fixed priority (bit 0 wins)
//            by default; round-robin from i_ptr when LED_SCHED_RR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module led_sched_arbiter
    import led_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [1:0]       o_sel
);

`ifdef LED_SCHED_RR_EN
    // Walk from the farthest candidate back to i_ptr so the nearest set bit wins.
    always_comb begin
        logic [1:0] w_idx;
        o_grant = '0;
        o_sel   = SRC_GAME;
        w_idx   = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = wrap_idx(i_ptr, 2'(k));
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_sel          = w_idx;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_grant = '0;
        o_sel   = SRC_GAME;
        if (i_req[0]) begin
            o_grant = 3'b001;
            o_sel   = SRC_GAME;
        end else if (i_req[1]) begin
            o_grant = 3'b010;
            o_sel   = SRC_FX;
        end else if (i_req[2]) begin
            o_grant = 3'b100;
            o_sel   = SRC_DBG;
        end
    end
`endif

endmodule : led_sched_arbiter
`default_nettype wire

// File: rtl/led_strip_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_strip_frame_scheduler
// Brief    : Per-frame owner selection, start pulse, busy tracking, latch gap
//            and frame-rate limiting for a shared WS2811 strip driver.
//            Optional macro LED_SCHED_RR_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module led_strip_frame_scheduler
    import led_sched_pkg::*;
#(
    parameter int LATCH_CYCLES = 3000,
    parameter int FRAME_PERIOD = 1000000,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_busy_drv,
    output logic [N_REQ-1:0] o_grant,
    output logic [1:0]       o_sel,
    output logic             o_start_frame,
    output logic             o_frame_done,
    output logic             o_drv_err,
    output logic [2:0]       o_db_state
);

    localparam int c_SS_W    = $clog2(FRAME_PERIOD + 1);
    localparam int c_CNT_MAX = (LATCH_CYCLES > BUSY_TIMEOUT) ? LATCH_CYCLES : BUSY_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_SS_W-1:0]  c_SS_FULL  = c_SS_W'(FRAME_PERIOD);
    // The IDLE->ARB->START pipeline is pre-counted so start pulses land
    // exactly FRAME_PERIOD cycles apart.
    localparam logic [c_SS_W-1:0]  c_SS_PIPE  = c_SS_W'(2);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(BUSY_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_TMO_WARN = c_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LAST = c_CNT_W'(LATCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_WARN = c_CNT_W'(LATCH_CYCLES - 2);

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [1:0]         r_sel;
    logic               r_start;
    logic               r_done;
    logic               r_err;
    logic [c_SS_W-1:0]  r_since;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]   w_win_grant;
    logic [1:0]         w_win_sel;
    logic [1:0]         w_ptr;

    led_sched_arbiter u_arbiter (
        .i_req   (i_req),
        .i_ptr   (w_ptr),
        .o_grant (w_win_grant),
        .o_sel   (w_win_sel)
    );

`ifdef LED_SCHED_RR_EN
    logic [1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SRC_GAME;
        end else if (r_state == S_ARB && |w_win_grant) begin
            r_ptr <= wrap_idx(w_win_sel, 2'd1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_sel   <= SRC_GAME;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_since <= c_SS_FULL;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (r_since != c_SS_FULL) begin
                r_since <= r_since + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_enable && |i_req && r_since == c_SS_FULL) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    // A request withdrawn during arbitration abandons the frame.
                    if (|w_win_grant) begin
                        r_grant <= w_win_grant;
                        r_sel   <= w_win_sel;
                        r_start <= 1'b1;
                        r_since <= c_SS_PIPE;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_cnt   <= c_CNT_W'(1);
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Timeout takes precedence in its final cycle so drv_err
                    // and the LATCH entry always agree.
                    if (r_cnt == c_TMO_LAST) begin
                        r_cnt   <= '0;
                        r_done  <= (LATCH_CYCLES == 1);
                        r_state <= S_LATCH;
                    end else if (i_busy_drv) begin
                        r_state <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_err <= (r_cnt == c_TMO_WARN);
                    end
                end
                S_SEND: begin
                    if (!i_busy_drv) begin
                        r_cnt   <= '0;
                        r_done  <= (LATCH_CYCLES == 1);
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == c_LAT_LAST) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == c_LAT_WARN);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_sel         = r_sel;
    assign o_start_frame = r_start;
    assign o_frame_done  = r_done;
    assign o_drv_err     = r_err;
    assign o_db_state    = r_state;

endmodule : led_strip_frame_scheduler
`default_nettype wire
